// File: rtl/drp_interleave_address_unit.sv
// DRP interleave address unit: maps a junction cycle index to z permuted
// left-neuron indices and their activation-bank word addresses, registered.
module drp_interleave_address_unit #(
  parameter int unsigned DRP_s = 3,
  parameter int unsigned DRP_p = 5,
  parameter int unsigned fo    = 2,
  parameter int unsigned fi    = 4,
  parameter int unsigned p     = 16,
  parameter int unsigned n     = 8,
  parameter int unsigned z     = 8,
  // Derived widths; not meant to be overridden.
  localparam int unsigned E    = fo * p,
  localparam int unsigned C    = E / z,
  localparam int unsigned CW   = (C > 1) ? $clog2(C) : 1,
  localparam int unsigned IW   = (p > 1) ? $clog2(p) : 1,
  localparam int unsigned AW   = ((p / z) > 1) ? $clog2(p / z) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [CW-1:0]   cycle_index,
  output logic [IW*z-1:0] memory_index,
  output logic [AW*z-1:0] address_package,
  output logic            valid
);

  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Seed folded into range once so the per-lane sum stays small.
  localparam longint unsigned Seed = longint'(DRP_s % E);

  // Reject parameter sets for which the permutation or bank mapping is ill-defined.
  if (fo * p != fi * n) begin : g_err_edges
    $error("fo*p must equal fi*n");
  end
  if ((E % z) != 0) begin : g_err_lanes
    $error("z must divide fo*p");
  end
  if ((p % z) != 0 || (p / z) < 2) begin : g_err_banks
    $error("p must be a multiple of z with p/z >= 2");
  end
  if (gcd(DRP_p, E) != 1) begin : g_err_coprime
    $error("DRP_p must be coprime with fo*p");
  end

  logic [IW*z-1:0] idx_d;
  logic [AW*z-1:0] addr_d;

  // Per-lane permutation and bank decode; 64-bit math keeps the product untruncated.
  for (genvar k = 0; k < z; k++) begin : g_lane
    logic [63:0] edge_idx;
    logic [63:0] perm;
    logic [63:0] neuron;

    assign edge_idx = 64'(cycle_index) * 64'(z) + 64'(k);
    assign perm     = (64'(DRP_p) * edge_idx + Seed) % 64'(E);
    assign neuron   = perm % 64'(p);
    // Bank is neuron mod z (implied by lane wiring); word address within it is neuron div z.
    assign idx_d[k*IW +: IW]  = IW'(neuron);
    assign addr_d[k*AW +: AW] = AW'(neuron / 64'(z));
  end

  // Output register: capture on en, otherwise hold data and drop valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memory_index    <= '0;
      address_package <= '0;
      valid           <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        memory_index    <= idx_d;
        address_package <= addr_d;
      end
    end
  end

endmodule

// File: tb/tb_drp_interleave_address_unit.sv
// Self-checking bench for drp_interleave_address_unit at default parameters.
module tb_drp_interleave_address_unit;

  localparam int unsigned MW = 32;
  localparam int unsigned AW = 8;
  localparam logic [MW-1:0] Mem0  = 32'h61C72D83;
  localparam logic [AW-1:0] Addr0 = 8'h26;
  localparam logic [MW-1:0] Mem1  = 32'hE94FA50B;
  localparam logic [AW-1:0] Addr1 = 8'hD9;

  typedef struct {
    logic          en;
    logic [1:0]    ci;
    logic [MW-1:0] mem;
    logic [AW-1:0] addr;
    logic          vld;
  } vec_t;

  typedef struct {
    logic [MW-1:0] mem;
    logic [AW-1:0] addr;
    logic          vld;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          en;
  logic [1:0]    cycle_index;
  logic [MW-1:0] memory_index;
  logic [AW-1:0] address_package;
  logic          valid;

  int checks;
  int errors;
  exp_t sb[$];
  int cnt[16];

  drp_interleave_address_unit dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .cycle_index     (cycle_index),
    .memory_index    (memory_index),
    .address_package (address_package),
    .valid           (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs, queue the expected result, compare after the edge.
  task automatic step(input string name, input logic e, input logic [1:0] ci,
                      input logic [MW-1:0] m, input logic [AW-1:0] a, input logic v);
    exp_t x;
    @(negedge clk);
    en = e;
    cycle_index = ci;
    x.mem = m;
    x.addr = a;
    x.vld = v;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard required entry", name);
    end else begin
      x = sb.pop_front();
      check({name, ".mem"}, 64'(memory_index), 64'(x.mem));
      check({name, ".addr"}, 64'(address_package), 64'(x.addr));
      check({name, ".valid"}, 64'(valid), 64'(x.vld));
    end
  endtask

  task automatic check_zero(input string name);
    check({name, ".mem"}, 64'(memory_index), 64'h0);
    check({name, ".addr"}, 64'(address_package), 64'h0);
    check({name, ".valid"}, 64'(valid), 64'h0);
  endtask

  vec_t vecs[9];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    en = 1'b0;
    cycle_index = '0;
    vecs[0] = '{1'b1, 2'd0, Mem0, Addr0, 1'b1};
    vecs[1] = '{1'b1, 2'd1, Mem1, Addr1, 1'b1};
    vecs[2] = '{1'b1, 2'd2, Mem0, Addr0, 1'b1};
    vecs[3] = '{1'b1, 2'd3, Mem1, Addr1, 1'b1};
    vecs[4] = '{1'b1, 2'd0, Mem0, Addr0, 1'b1};
    vecs[5] = '{1'b1, 2'd1, Mem1, Addr1, 1'b1};
    vecs[6] = '{1'b0, 2'd2, Mem1, Addr1, 1'b0};
    vecs[7] = '{1'b0, 2'd0, Mem1, Addr1, 1'b0};
    vecs[8] = '{1'b1, 2'd2, Mem0, Addr0, 1'b1};

    #12;
    check_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].ci, vecs[i].mem, vecs[i].addr,
           vecs[i].vld);
    end

    // Async reset between edges clears outputs without a clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // Full sweep: every neuron index appears exactly fo times across lanes.
    for (int j = 0; j < 16; j++) cnt[j] = 0;
    for (int c = 0; c < 4; c++) begin
      step($sformatf("sweep%0d", c), 1'b1, 2'(c), (c % 2 == 0) ? Mem0 : Mem1,
           (c % 2 == 0) ? Addr0 : Addr1, 1'b1);
      for (int k = 0; k < 8; k++) cnt[memory_index[k*4 +: 4]]++;
    end
    for (int j = 0; j < 16; j++) check($sformatf("cover_idx%0d", j), 64'(cnt[j]), 64'd2);

    // Reset mid-sweep while cycle_index=2 is pending, then clean restart.
    step("mid0", 1'b1, 2'd0, Mem0, Addr0, 1'b1);
    step("mid1", 1'b1, 2'd1, Mem1, Addr1, 1'b1);
    @(negedge clk);
    en = 1'b1;
    cycle_index = 2'd2;
    #2;
    reset = 1'b1;
    #1;
    check_zero("mid_reset_now");
    @(posedge clk);
    #1;
    check_zero("mid_reset_held");
    @(negedge clk);
    reset = 1'b0;
    step("restart0", 1'b1, 2'd0, Mem0, Addr0, 1'b1);
    step("restart1", 1'b1, 2'd1, Mem1, Addr1, 1'b1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drp_interleave_address_unit.md
Name: drp_interleave_address_unit

Overview:
- Registered edge-to-memory address generator for one sparse junction of the DNN datapath.
- Each cycle it maps a junction cycle index to z interleaved left-neuron indices using a relative-prime (DRP) permutation with offset seed.
- It then decodes each neuron index into its word address inside its activation memory bank.
- It feeds the activation memory read ports ahead of the z parallel edge processors.

Parameters:
- DRP_s, 3, permutation offset (seed); reduced mod fo*p.
- DRP_p, 5, permutation multiplier; must be coprime with fo*p.
- fo, 2, fan-out per left neuron.
- fi, 4, fan-in per right neuron.
- p, 16, left-layer neuron count.
- n, 8, right-layer neuron count.
- z, 8, edges processed per cycle (lanes) and number of activation banks.
- Legality (elaboration error otherwise): fo*p == fi*n; z divides fo*p; p divisible by z; p/z >= 2; gcd(DRP_p, fo*p) == 1.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample cycle_index this cycle.
- cycle_index  input  clog2(fo*p/z)  junction cycle number, 0..fo*p/z-1.
- memory_index  output  clog2(p)*z  z lanes of left-neuron index; lane k at bits [k*clog2(p) +: clog2(p)].
- address_package  output  clog2(p/z)*z  z lanes of bank word address; lane k at bits [k*clog2(p/z) +: clog2(p/z)].
- valid  output  1  outputs correspond to a sampled cycle_index.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high.
- Reset: memory_index, address_package and valid go to 0 immediately, regardless of clk. Reset mid-operation discards the in-flight result. The first rising edge after reset is deasserted with en=1 produces valid output.
- Parameter derivations:
  - E = fo*p (edge count).
  - C = E/z (cycles per junction).
- Edge index for lane k: e = cycle_index*z + k, in range 0..E-1.
- Permutation: pi(e) = (DRP_p*e + DRP_s) mod E. Compute with full-width product (no truncation before the mod).
- Neuron index: idx_k = pi(e) mod p, giving clog2(p) bits.
- Bank decode: lane k reads bank (idx_k mod z); address_k = idx_k div z, giving clog2(p/z) bits.
- Latency: 1 cycle. On a rising edge with en=1, register idx_k / address_k for all lanes and set valid=1.
- Hold: on a rising edge with en=0, memory_index and address_package hold their values and valid=0.
- Wrap-around: cycle_index is used as given. Values >= C are out of contract; the output is the formula result mod E.
- Coverage property: over cycles 0..C-1, every neuron index 0..p-1 appears exactly fo times across all lanes.
- Concurrency: no handshake back-pressure. The unit accepts every en cycle.
- Implementation: purely combinational mapping plus one output register stage. The generate loop over lanes is parameter-driven; no hard-coded constants.

Test Plan:
1. Reset asserted asynchronously between edges -> memory_index=0x00000000, address_package=0x00, valid=0 without waiting for clk.
2. en=1, cycle_index=0 (defaults) -> next edge memory_index=0x61C72D83 (lanes 3,8,13,2,7,12,1,6), address_package=0x26, valid=1.
3. en=1, cycle_index=1 -> memory_index=0xE94FA50B (lanes 11,0,5,10,15,4,9,14), address_package=0xD9.
4. cycle_index sweep 0,1,2,3,0 with en=1 -> cycle 2 reproduces cycle 0 result and cycle 3 reproduces cycle 1. Each index 0..15 appears exactly twice per sweep. The counter wrap from 3 to 0 yields the cycle-0 result again.
5. en=0 after cycle 1 result while cycle_index changes -> outputs hold 0xE94FA50B / 0xD9, valid=0.
6. Reset pulsed mid-sweep at cycle_index=2 -> outputs 0 immediately. Sweep restarts cleanly with the cycle-0 result after reset release.
